// File: rtl/conv_pkg.sv
// Shared constants, state encoding and row-slice helpers for the conv tile.
// ZERO_ROW_SKIP_EN adds the SKIP state for all-zero weight rows.
package conv_pkg;

  localparam int DEF_WIN_SIZE  = 3;
  localparam int DEF_IN_WIDTH  = 5;
  localparam int DEF_W_WIDTH   = 8;
  localparam int DEF_ACC_WIDTH = 15;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_DROP  = 3'd2;
  localparam logic [2:0] ST_OUT   = 3'd3;
  localparam logic [2:0] ST_SKIP  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    DROP  = ST_DROP,
`ifdef ZERO_ROW_SKIP_EN
    SKIP  = ST_SKIP,
`endif
    OUT   = ST_OUT
  } state_t;

  function automatic int row_off(input int r, input int row_w);
    return r * row_w;
  endfunction

endpackage

// File: rtl/pe_row_sequencer.sv
// Runs one 3x3 window through a single PE row by row, chaining partials.
// Build with ZERO_ROW_SKIP_EN to bypass rows whose weights are all zero.
module pe_row_sequencer
  import conv_pkg::*;
#(
  parameter int WIN_SIZE  = DEF_WIN_SIZE,
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int W_WIDTH   = DEF_W_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic wload_valid,
  input  logic [WIN_SIZE*WIN_SIZE*W_WIDTH-1:0] wload_data,
  input  logic win_valid,
  output logic win_ready,
  input  logic [WIN_SIZE*WIN_SIZE*IN_WIDTH-1:0] win_data,
  output logic pe_start,
  output logic [WIN_SIZE*IN_WIDTH-1:0] pe_in_data,
  output logic [WIN_SIZE*W_WIDTH-1:0] pe_in_filter,
  output logic [ACC_WIDTH-1:0] pe_in_partial,
  input  logic [ACC_WIDTH-1:0] pe_out_data,
  input  logic pe_finished,
  output logic res_valid,
  input  logic res_ready,
  output logic [ACC_WIDTH-1:0] res_data,
  output logic busy
);

  localparam int DROW = WIN_SIZE * IN_WIDTH;
  localparam int WROW = WIN_SIZE * W_WIDTH;

  state_t state;
  logic [1:0] row;
  logic [ACC_WIDTH-1:0] partial;
  logic [WIN_SIZE*WIN_SIZE*W_WIDTH-1:0] filt_q;
  logic [WIN_SIZE*WIN_SIZE*IN_WIDTH-1:0] win_q;

  logic [DROW-1:0] d_rows [WIN_SIZE];
  logic [WROW-1:0] w_rows [WIN_SIZE];

  always_comb begin
    for (int r = 0; r < WIN_SIZE; r++) begin
      d_rows[r] = win_q[row_off(r, DROW) +: DROW];
      w_rows[r] = filt_q[row_off(r, WROW) +: WROW];
    end
  end

  assign pe_in_data    = d_rows[row];
  assign pe_in_filter  = w_rows[row];
  assign pe_in_partial = (row == 2'd0) ? '0 : partial;
  assign win_ready     = (state == IDLE);
  assign busy          = (state != IDLE);

`ifdef ZERO_ROW_SKIP_EN
  logic [WIN_SIZE-1:0] w_zero;
  logic first_zero;

  // Row 0 is judged on the weights that will be live after this edge.
  always_comb begin
    for (int r = 0; r < WIN_SIZE; r++)
      w_zero[r] = (w_rows[r] == '0);
    first_zero = wload_valid ? (wload_data[WROW-1:0] == '0)
                             : w_zero[0];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      row       <= '0;
      partial   <= '0;
      filt_q    <= '0;
      win_q     <= '0;
      pe_start  <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (wload_valid)
            filt_q <= wload_data;
          if (win_valid) begin
            win_q   <= win_data;
            row     <= '0;
            partial <= '0;
`ifdef ZERO_ROW_SKIP_EN
            if (first_zero) begin
              state <= SKIP;
            end else begin
              state    <= ISSUE;
              pe_start <= 1'b1;
            end
`else
            state    <= ISSUE;
            pe_start <= 1'b1;
`endif
          end
        end
        ISSUE: begin
          if (pe_finished) begin
            partial  <= pe_out_data;
            pe_start <= 1'b0;
            state    <= DROP;
          end
        end
        DROP: begin
          if (!pe_finished) begin
            if (row < 2'd2) begin
              row <= row + 2'd1;
`ifdef ZERO_ROW_SKIP_EN
              if (w_zero[row + 2'd1]) begin
                state <= SKIP;
              end else begin
                state    <= ISSUE;
                pe_start <= 1'b1;
              end
`else
              state    <= ISSUE;
              pe_start <= 1'b1;
`endif
            end else begin
              res_data  <= partial;
              res_valid <= 1'b1;
              state     <= OUT;
            end
          end
        end
`ifdef ZERO_ROW_SKIP_EN
        SKIP: begin
          if (row < 2'd2) begin
            row <= row + 2'd1;
            if (w_zero[row + 2'd1]) begin
              state <= SKIP;
            end else begin
              state    <= ISSUE;
              pe_start <= 1'b1;
            end
          end else begin
            res_data  <= partial;
            res_valid <= 1'b1;
            state     <= OUT;
          end
        end
`endif
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
